// File: rtl/datapath_arbiter.sv
// Bus-ownership arbiter between the instruction Controller and the DataPath.
// Passes core control through, or stalls the core at a fetch boundary to run a short debug transaction.
module datapath_arbiter #(
  parameter int         WIDTH    = 16,
  parameter int         D_ADDR_W = 8,
  parameter int         R_ADDR_W = 4,
  parameter logic [3:0] ALU_PASS = 4'd0
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic [D_ADDR_W-1:0] core_D_addr,
  input  logic                core_D_wr,
  input  logic                core_RF_s,
  input  logic                core_RF_W_en,
  input  logic [R_ADDR_W-1:0] core_RF_W_addr,
  input  logic [R_ADDR_W-1:0] core_RF_A_addr,
  input  logic [R_ADDR_W-1:0] core_RF_B_addr,
  input  logic [3:0]          core_ALU_sel,
  input  logic                core_boundary,
  output logic                core_stall,
  output logic [D_ADDR_W-1:0] dp_D_addr,
  output logic                dp_D_wr,
  output logic                dp_RF_s,
  output logic                dp_RF_W_en,
  output logic [R_ADDR_W-1:0] dp_RF_W_addr,
  output logic [R_ADDR_W-1:0] dp_RF_A_addr,
  output logic [R_ADDR_W-1:0] dp_RF_B_addr,
  output logic [3:0]          dp_ALU_sel,
  input  logic [WIDTH-1:0]    ALU_Out,
  input  logic                dbg_req,
  input  logic [1:0]          dbg_op,
  input  logic [R_ADDR_W-1:0] dbg_raddr,
  input  logic [D_ADDR_W-1:0] dbg_daddr,
  output logic                dbg_ack,
  output logic                dbg_err,
  output logic [WIDTH-1:0]    dbg_rdata,
  output logic                owner
);

  localparam logic [1:0] S_CORE  = 2'd0;
  localparam logic [1:0] S_EXEC1 = 2'd1;
  localparam logic [1:0] S_EXEC2 = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_STORE = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] OP_RSVD  = 2'b11;

  logic [1:0]          state;
  logic [1:0]          state_nxt;
  logic [1:0]          op_q;
  logic [R_ADDR_W-1:0] raddr_q;
  logic [D_ADDR_W-1:0] daddr_q;
  logic                grant;
  logic                exec;

  // Grant only at a fetch boundary and never while reset is asserted.
  assign grant = (state == S_CORE) && dbg_req && core_boundary && Reset;
  assign exec  = (state == S_EXEC1) || (state == S_EXEC2);

  always_comb begin
    state_nxt = state;
    case (state)
      S_CORE:  if (grant) state_nxt = S_EXEC1;
      S_EXEC1: state_nxt = (op_q == OP_RSVD) ? S_DONE : S_EXEC2;
      S_EXEC2: state_nxt = S_DONE;
      default: state_nxt = S_CORE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state     <= S_CORE;
      op_q      <= '0;
      raddr_q   <= '0;
      daddr_q   <= '0;
      dbg_rdata <= '0;
    end else begin
      state <= state_nxt;
      if (grant) begin
        op_q    <= dbg_op;
        raddr_q <= dbg_raddr;
        daddr_q <= dbg_daddr;
      end
      if (state == S_EXEC2 && op_q == OP_READ)
        dbg_rdata <= ALU_Out;
    end
  end

  // NOTE: every output gets a default before the case so no path infers a latch.
  always_comb begin
    dp_D_addr    = '0;
    dp_D_wr      = 1'b0;
    dp_RF_s      = 1'b0;
    dp_RF_W_en   = 1'b0;
    dp_RF_W_addr = '0;
    dp_RF_A_addr = '0;
    dp_RF_B_addr = '0;
    dp_ALU_sel   = '0;
    core_stall   = 1'b0;

    if (state == S_CORE) begin
      dp_D_addr    = core_D_addr;
      dp_D_wr      = core_D_wr;
      dp_RF_s      = core_RF_s;
      dp_RF_W_en   = core_RF_W_en;
      dp_RF_W_addr = core_RF_W_addr;
      dp_RF_A_addr = core_RF_A_addr;
      dp_RF_B_addr = core_RF_B_addr;
      dp_ALU_sel   = core_ALU_sel;
      core_stall   = grant;
    end else begin
      core_stall = Reset;
      if (exec) begin
        case (op_q)
          OP_LOAD: begin
            dp_D_addr    = daddr_q;
            dp_RF_s      = 1'b1;
            dp_RF_W_addr = raddr_q;
            dp_RF_W_en   = (state == S_EXEC2) && Reset;
          end
          OP_STORE: begin
            dp_D_addr    = daddr_q;
            dp_RF_A_addr = raddr_q;
            dp_D_wr      = (state == S_EXEC2) && Reset;
          end
          OP_READ: begin
            dp_RF_A_addr = raddr_q;
            dp_ALU_sel   = ALU_PASS;
          end
          default: ;
        endcase
      end
    end
  end

  assign owner   = (state != S_CORE);
  assign dbg_ack = (state == S_DONE) && Reset;
  assign dbg_err = dbg_ack && (op_q == OP_RSVD);

endmodule

// File: tb/tb_datapath_arbiter.sv
// Bench for datapath_arbiter: hosts a small register-file/memory DataPath and
// checks pass-through, debug transactions and reset abort against a transaction-level model.
module tb_datapath_arbiter;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [7:0]  core_D_addr;
  logic        core_D_wr;
  logic        core_RF_s;
  logic        core_RF_W_en;
  logic [3:0]  core_RF_W_addr;
  logic [3:0]  core_RF_A_addr;
  logic [3:0]  core_RF_B_addr;
  logic [3:0]  core_ALU_sel;
  logic        core_boundary;
  logic        core_stall;
  logic [7:0]  dp_D_addr;
  logic        dp_D_wr;
  logic        dp_RF_s;
  logic        dp_RF_W_en;
  logic [3:0]  dp_RF_W_addr;
  logic [3:0]  dp_RF_A_addr;
  logic [3:0]  dp_RF_B_addr;
  logic [3:0]  dp_ALU_sel;
  logic [15:0] ALU_Out;
  logic        dbg_req;
  logic [1:0]  dbg_op;
  logic [3:0]  dbg_raddr;
  logic [7:0]  dbg_daddr;
  logic        dbg_ack;
  logic        dbg_err;
  logic [15:0] dbg_rdata;
  logic        owner;

  int n_checks = 0;
  int n_fail   = 0;

  datapath_arbiter dut (
    .Clk(Clk), .Reset(Reset),
    .core_D_addr(core_D_addr), .core_D_wr(core_D_wr), .core_RF_s(core_RF_s),
    .core_RF_W_en(core_RF_W_en), .core_RF_W_addr(core_RF_W_addr),
    .core_RF_A_addr(core_RF_A_addr), .core_RF_B_addr(core_RF_B_addr),
    .core_ALU_sel(core_ALU_sel), .core_boundary(core_boundary), .core_stall(core_stall),
    .dp_D_addr(dp_D_addr), .dp_D_wr(dp_D_wr), .dp_RF_s(dp_RF_s), .dp_RF_W_en(dp_RF_W_en),
    .dp_RF_W_addr(dp_RF_W_addr), .dp_RF_A_addr(dp_RF_A_addr), .dp_RF_B_addr(dp_RF_B_addr),
    .dp_ALU_sel(dp_ALU_sel), .ALU_Out(ALU_Out),
    .dbg_req(dbg_req), .dbg_op(dbg_op), .dbg_raddr(dbg_raddr), .dbg_daddr(dbg_daddr),
    .dbg_ack(dbg_ack), .dbg_err(dbg_err), .dbg_rdata(dbg_rdata), .owner(owner)
  );

  always #5 Clk = ~Clk;

  function automatic logic [15:0] rf_init(input int i);
    return 16'hA000 ^ (16'(i) * 16'h0111);
  endfunction

  function automatic logic [15:0] mem_init(input int i);
    return (16'(i) * 16'h0101) ^ 16'h5A5A;
  endfunction

  // Environment DataPath driven only by the dp_* bus.
  logic [15:0] env_rf  [16];
  logic [15:0] env_mem [256];
  logic        env_ready = 1'b0;

  assign ALU_Out = (dp_ALU_sel == 4'd0) ? env_rf[dp_RF_A_addr]
                                        : env_rf[dp_RF_A_addr] + env_rf[dp_RF_B_addr];

  always @(posedge Clk) begin
    if (!env_ready) begin
      for (int i = 0; i < 16; i++)  env_rf[i]  <= rf_init(i);
      for (int i = 0; i < 256; i++) env_mem[i] <= mem_init(i);
      env_ready <= 1'b1;
    end else begin
      if (dp_D_wr)    env_mem[dp_D_addr]   <= env_rf[dp_RF_A_addr];
      if (dp_RF_W_en) env_rf[dp_RF_W_addr] <= dp_RF_s ? env_mem[dp_D_addr] : ALU_Out;
    end
  end

  // Transaction-level expectation of the DataPath contents and debug read register.
  logic [15:0] exp_rf  [16];
  logic [15:0] exp_mem [256];
  logic [15:0] exp_rdata;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic core_quiet();
    core_D_addr = '0; core_D_wr = 1'b0; core_RF_s = 1'b0; core_RF_W_en = 1'b0;
    core_RF_W_addr = '0; core_RF_A_addr = '0; core_RF_B_addr = '0; core_ALU_sel = '0;
  endtask

  task automatic check_arrays(input string name);
    int bad;
    bad = 0;
    for (int i = 0; i < 16; i++)  if (env_rf[i] !== exp_rf[i]) bad++;
    for (int i = 0; i < 256; i++) if (env_mem[i] !== exp_mem[i]) bad++;
    check(name, 64'(bad), 64'd0);
  endtask

  // One debug transaction: optional wait with boundary low, grant, bounded wait for ack.
  task automatic do_txn(input logic [1:0] op, input logic [3:0] r, input logic [7:0] d,
                        input int pre_wait);
    int          lat;
    logic        err_at_ack;
    logic        stall_at_ack;
    logic [8:0]  wr_mask;
    logic [8:0]  we_mask;
    logic [20:0] info1, info2, exp_info;
    logic [7:0]  exp_addr;
    int          exp_lat;

    core_quiet();
    dbg_op = op; dbg_raddr = r; dbg_daddr = d; dbg_req = 1'b1; core_boundary = 1'b0;
    for (int i = 0; i < pre_wait; i++) begin
      exp_addr    = 8'($urandom);
      core_D_addr = exp_addr;
      #3;
      check("wait_no_stall", {owner, core_stall}, 2'b00);
      check("wait_passthru", dp_D_addr, exp_addr);
      tick();
    end
    core_boundary = 1'b1;
    #3;
    check("grant_stall", {core_stall, owner, dbg_ack}, 3'b100);
    tick();

    // Operands and core bus scrambled after grant: both must be ignored.
    dbg_op = 2'($urandom); dbg_raddr = 4'($urandom); dbg_daddr = 8'($urandom);
    core_D_wr = 1'b1; core_RF_W_en = 1'b1; core_RF_s = 1'($urandom);
    core_D_addr = 8'($urandom); core_RF_W_addr = 4'($urandom);
    core_RF_A_addr = 4'($urandom); core_ALU_sel = 4'($urandom_range(1, 15));

    lat = 0; err_at_ack = 1'b0; stall_at_ack = 1'b0;
    wr_mask = '0; we_mask = '0; info1 = '0; info2 = '0;
    for (int k = 1; k <= 8; k++) begin
      #3;
      wr_mask[k] = dp_D_wr;
      we_mask[k] = dp_RF_W_en;
      if (k == 1) info1 = {dp_D_addr, dp_RF_A_addr, dp_RF_W_addr, dp_RF_s, dp_ALU_sel};
      if (k == 2) info2 = {dp_D_addr, dp_RF_A_addr, dp_RF_W_addr, dp_RF_s, dp_ALU_sel};
      if (dbg_ack) begin
        lat = k; err_at_ack = dbg_err; stall_at_ack = core_stall;
        break;
      end
      tick();
    end
    dbg_req = 1'b0;
    core_quiet();

    exp_lat = (op == 2'b11) ? 2 : 3;
    case (op)
      2'b00:   exp_info = {d, 4'h0, r, 1'b1, 4'h0};
      2'b01:   exp_info = {d, r, 4'h0, 1'b0, 4'h0};
      2'b10:   exp_info = {8'h00, r, 4'h0, 1'b0, 4'h0};
      default: exp_info = '0;
    endcase
    check("ack_latency", 64'(lat), 64'(exp_lat));
    check("ack_err_stall", {err_at_ack, stall_at_ack}, {(op == 2'b11), 1'b1});
    check("d_wr_cycles", wr_mask, (op == 2'b01) ? 9'b000000100 : 9'b0);
    check("rf_we_cycles", we_mask, (op == 2'b00) ? 9'b000000100 : 9'b0);
    check("exec1_bus", info1, (op == 2'b11) ? 21'h0 : exp_info);
    check("exec2_bus", info2, (op == 2'b11) ? 21'h0 : exp_info);

    tick();
    #3;
    check("resume", {owner, core_stall, dbg_ack}, 3'b000);
    case (op)
      2'b00: begin
        exp_rf[r] = exp_mem[d];
        check("load_effect", env_rf[r], exp_rf[r]);
      end
      2'b01: begin
        exp_mem[d] = exp_rf[r];
        check("store_effect", env_mem[d], exp_mem[d]);
      end
      2'b10: exp_rdata = exp_rf[r];
      default: ;
    endcase
    check("rdata", dbg_rdata, exp_rdata);
    tick();
  endtask

  typedef struct {
    logic [7:0]  d_addr;
    logic        d_wr;
    logic        rf_s;
    logic        rf_w_en;
    logic [3:0]  w_addr;
    logic [3:0]  a_addr;
    logic [3:0]  b_addr;
    logic [3:0]  alu_sel;
    logic        req;
    logic        boundary;
    logic [26:0] exp_bus;
  } pt_vec_t;

  pt_vec_t pt_tab [4];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [15:0] mem_wdata, rf_wdata;

    pt_tab[0] = '{8'h3C, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, {8'h3C, 3'b100, 16'h0000}};
    pt_tab[1] = '{8'h11, 1'b0, 1'b1, 1'b1, 4'h2, 4'h3, 4'h4, 4'h5, 1'b1, 1'b0, {8'h11, 3'b011, 16'h2345}};
    pt_tab[2] = '{8'hFF, 1'b0, 1'b0, 1'b0, 4'hF, 4'hF, 4'hF, 4'hF, 1'b0, 1'b1, {8'hFF, 3'b000, 16'hFFFF}};
    pt_tab[3] = '{8'h00, 1'b0, 1'b0, 1'b1, 4'h7, 4'h1, 4'h2, 4'h0, 1'b0, 1'b1, {8'h00, 3'b001, 16'h7120}};

    for (int i = 0; i < 16; i++)  exp_rf[i]  = rf_init(i);
    for (int i = 0; i < 256; i++) exp_mem[i] = mem_init(i);
    exp_rdata = '0;

    // Reset held with a pending request: nothing may be granted.
    core_quiet();
    Reset = 1'b0; dbg_req = 1'b1; core_boundary = 1'b1;
    dbg_op = 2'b01; dbg_raddr = 4'h1; dbg_daddr = 8'h01;
    tick();
    tick();
    #3;
    check("reset_state", {owner, core_stall, dbg_ack, dbg_err}, 4'b0000);
    check("reset_rdata", dbg_rdata, 16'h0000);
    tick();
    Reset = 1'b1; dbg_req = 1'b0;
    #3;
    check("idle_after_reset", {owner, core_stall, dbg_ack}, 3'b000);
    tick();

    // Pass-through vectors in CORE, none of which forms a grant.
    foreach (pt_tab[i]) begin
      core_D_addr = pt_tab[i].d_addr; core_D_wr = pt_tab[i].d_wr;
      core_RF_s = pt_tab[i].rf_s; core_RF_W_en = pt_tab[i].rf_w_en;
      core_RF_W_addr = pt_tab[i].w_addr; core_RF_A_addr = pt_tab[i].a_addr;
      core_RF_B_addr = pt_tab[i].b_addr; core_ALU_sel = pt_tab[i].alu_sel;
      dbg_req = pt_tab[i].req; core_boundary = pt_tab[i].boundary;
      #3;
      check($sformatf("passthru_%0d", i),
            {dp_D_addr, dp_D_wr, dp_RF_s, dp_RF_W_en, dp_RF_W_addr, dp_RF_A_addr,
             dp_RF_B_addr, dp_ALU_sel}, pt_tab[i].exp_bus);
      check($sformatf("passthru_stall_%0d", i), {owner, core_stall}, 2'b00);
      mem_wdata = exp_rf[pt_tab[i].a_addr];
      rf_wdata  = pt_tab[i].rf_s ? exp_mem[pt_tab[i].d_addr]
                : (pt_tab[i].alu_sel == 4'd0) ? exp_rf[pt_tab[i].a_addr]
                : exp_rf[pt_tab[i].a_addr] + exp_rf[pt_tab[i].b_addr];
      if (pt_tab[i].d_wr)    exp_mem[pt_tab[i].d_addr] = mem_wdata;
      if (pt_tab[i].rf_w_en) exp_rf[pt_tab[i].w_addr]  = rf_wdata;
      tick();
    end
    dbg_req = 1'b0;
    core_quiet();
    tick();
    check_arrays("passthru_arrays");

    // Store R5 -> D[0x20], load D[0x20] -> R10, read R10 back.
    do_txn(2'b01, 4'h5, 8'h20, 0);
    do_txn(2'b00, 4'hA, 8'h20, 0);
    do_txn(2'b10, 4'hA, 8'h00, 0);
    check("readback_value", dbg_rdata, rf_init(5));

    // Request waits five cycles with boundary low, then reserved op.
    do_txn(2'b10, 4'h7, 8'h00, 5);
    do_txn(2'b11, 4'h3, 8'h44, 0);

    // Reset asserted during EXEC2 of a store aborts it.
    core_quiet();
    dbg_op = 2'b01; dbg_raddr = 4'h3; dbg_daddr = 8'h50; dbg_req = 1'b1; core_boundary = 1'b1;
    tick();
    tick();
    Reset = 1'b0;
    #3;
    check("abort_d_wr", {dp_D_wr, core_stall}, 2'b00);
    dbg_req = 1'b0;
    tick();
    #3;
    check("abort_owner_ack", {owner, dbg_ack}, 2'b00);
    check("abort_rdata", dbg_rdata, 16'h0000);
    exp_rdata = '0;
    tick();
    Reset = 1'b1;
    #3;
    check("abort_no_late_ack", {owner, dbg_ack}, 2'b00);
    check("abort_mem", env_mem[8'h50], exp_mem[8'h50]);
    tick();

    // Randomized transactions against the model.
    for (int n = 0; n < 40; n++)
      do_txn(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
             8'($urandom_range(0, 255)), $urandom_range(0, 2));
    check_arrays("final_arrays");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
